fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the CPU front end. Owns the fetch PC, drives the synchronous-read instruction BRAM (1-cycle read latency), and pairs each returned instruction with the PC that fetched it. Downstream stalls and branch/jump redirects from later stages are absorbed here. Replaces the free-running PC-delay register with a controlled fetch path that supports stalling and flushing.

---
 rtl/fetch_ctrl_pkg.sv | 15 +
 rtl/fetch_skid_buf.sv | 33 +++
 rtl/fetch_ctrl.sv | 99 +++++++++
 tb/tb_fetch_ctrl.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch sequencer.
package fetch_ctrl_pkg;

   localparam int unsigned FETCH_PC_WIDTH    = 32;
   localparam int unsigned FETCH_INSTR_WIDTH = 32;
   localparam int unsigned FETCH_PC_STEP     = 4;
   localparam int unsigned FETCH_RESET_PC    = 0;

   typedef enum logic [1:0] {
      FETCH_BOOT = 2'd0,
      FETCH_RUN  = 2'd1,
      FETCH_HOLD = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry hold buffer for a fetched PC/instruction pair while decode stalls.
module fetch_skid_buf #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned INSTR_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   load,
   input  logic                   clear,
   input  logic [PC_WIDTH-1:0]    load_pc,
   input  logic [INSTR_WIDTH-1:0] load_instr,
   output logic                   valid,
   output logic [PC_WIDTH-1:0]    pc,
   output logic [INSTR_WIDTH-1:0] instr
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end
   end

   // NOTE: payload registers carry no reset; valid alone qualifies them, which keeps the reset net off the datapath.
   always_ff @(posedge clk) begin
      if (load) begin
         pc    <= load_pc;
         instr <= load_instr;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives the 1-cycle BRAM, absorbs stalls and redirects.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned         PC_WIDTH    = FETCH_PC_WIDTH,
   parameter int unsigned         INSTR_WIDTH = FETCH_INSTR_WIDTH,
   parameter int unsigned         PC_STEP     = FETCH_PC_STEP,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = PC_WIDTH'(FETCH_RESET_PC)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   stall_i,
   input  logic                   redirect_i,
   input  logic [PC_WIDTH-1:0]    redirect_target_i,
   output logic                   imem_en_o,
   output logic [PC_WIDTH-1:0]    imem_addr_o,
   input  logic [INSTR_WIDTH-1:0] imem_rdata_i,
   output logic                   if_valid_o,
   output logic [PC_WIDTH-1:0]    if_pc_o,
   output logic [INSTR_WIDTH-1:0] if_instr_o
);

   fetch_state_e            state_q, state_d;
   logic [PC_WIDTH-1:0]     fetch_pc;
   logic                    rsp_valid;
   logic [PC_WIDTH-1:0]     rsp_pc;
   logic                    buf_valid;
   logic [PC_WIDTH-1:0]     buf_pc;
   logic [INSTR_WIDTH-1:0]  buf_instr;
   logic                    issue;
   logic                    buf_load;
   logic                    buf_clear;

   // NOTE: every combinational output gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FETCH_BOOT: state_d = FETCH_RUN;
         FETCH_RUN:  if (stall_i && rsp_valid && !redirect_i) state_d = FETCH_HOLD;
         FETCH_HOLD: if (!stall_i || redirect_i) state_d = FETCH_RUN;
         default:    state_d = FETCH_BOOT;
      endcase
   end

   // Capture the response the cycle the stall first hits, since BRAM dout is not trusted afterwards.
   assign buf_load  = (state_q == FETCH_RUN)  && (state_d == FETCH_HOLD);
   assign buf_clear = (state_q == FETCH_HOLD) && (state_d == FETCH_RUN);

   fetch_skid_buf #(
      .PC_WIDTH    (PC_WIDTH),
      .INSTR_WIDTH (INSTR_WIDTH)
   ) u_skid (
      .clk        (clk),
      .rst        (rst),
      .load       (buf_load),
      .clear      (buf_clear),
      .load_pc    (rsp_pc),
      .load_instr (imem_rdata_i),
      .valid      (buf_valid),
      .pc         (buf_pc),
      .instr      (buf_instr)
   );

   always_comb begin
      if (buf_valid) begin
         if_valid_o = 1'b1;
         if_pc_o    = buf_pc;
         if_instr_o = buf_instr;
      end else begin
         if_valid_o = rsp_valid;
         if_pc_o    = rsp_pc;
         if_instr_o = imem_rdata_i;
      end
      if (redirect_i) if_valid_o = 1'b0;
   end

   assign issue       = !rst && (state_q != FETCH_BOOT) && (redirect_i || !stall_i || !if_valid_o);
   assign imem_en_o   = issue;
   assign imem_addr_o = redirect_i ? redirect_target_i : fetch_pc;

   // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FETCH_BOOT;
         fetch_pc  <= RESET_PC;
         rsp_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         if (issue) begin
            fetch_pc  <= imem_addr_o + PC_WIDTH'(PC_STEP);
            rsp_valid <= 1'b1;
            rsp_pc    <= imem_addr_o;
         end else begin
            rsp_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: stream-level reference model plus directed literal pins.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_i;
   logic        redirect_i;
   logic [31:0] redirect_target_i;
   logic        imem_en_o;
   logic [31:0] imem_addr_o;
   logic [31:0] imem_rdata_i;
   logic        if_valid_o;
   logic [31:0] if_pc_o;
   logic [31:0] if_instr_o;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   fetch_ctrl dut (
      .clk               (clk),
      .rst               (rst),
      .stall_i           (stall_i),
      .redirect_i        (redirect_i),
      .redirect_target_i (redirect_target_i),
      .imem_en_o         (imem_en_o),
      .imem_addr_o       (imem_addr_o),
      .imem_rdata_i      (imem_rdata_i),
      .if_valid_o        (if_valid_o),
      .if_pc_o           (if_pc_o),
      .if_instr_o        (if_instr_o)
   );

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a ^ 32'h5A5A_0000) + 32'h0000_1357;
   endfunction

   // Instruction memory: 1-cycle read, garbage on dout whenever the read is not enabled.
   always @(posedge clk) begin
      if (imem_en_o) imem_rdata_i <= instr_of(imem_addr_o);
      else           imem_rdata_i <= $urandom();
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: tracks the PC the next delivered instruction must carry and cycles since reset.
   int          warm = 0;
   logic        rst_prev = 1'b0;
   logic [31:0] exp_next = 32'h0;

   always @(negedge clk) begin
      logic exp_valid;
      logic exp_en;
      exp_valid = !rst && (warm >= 2) && !redirect_i;
      exp_en    = !rst && (warm >= 1) && (redirect_i || !stall_i || !exp_valid);
      check("model_en", {31'b0, imem_en_o}, {31'b0, exp_en});
      if (rst) begin
         if (rst_prev) check("model_rst_valid", {31'b0, if_valid_o}, 32'h0);
      end else begin
         check("model_valid", {31'b0, if_valid_o}, {31'b0, exp_valid});
         if (exp_valid) begin
            check("model_pc", if_pc_o, exp_next);
            check("model_instr", if_instr_o, instr_of(exp_next));
         end
         if (exp_en)
            check("model_addr", imem_addr_o,
                  redirect_i ? redirect_target_i : (exp_valid ? exp_next + 32'd4 : exp_next));
      end
      if (rst) begin
         warm     = 0;
         exp_next = 32'h0;
      end else begin
         if (warm < 3) warm++;
         if (redirect_i)                exp_next = redirect_target_i;
         else if (exp_valid && !stall_i) exp_next = exp_next + 32'd4;
      end
      rst_prev = rst;
   end

   task automatic drive(input logic r, input logic s, input logic d, input logic [31:0] t);
      @(posedge clk);
      #1;
      rst               = r;
      stall_i           = s;
      redirect_i        = d;
      redirect_target_i = t;
      @(negedge clk);
   endtask

   initial begin
      logic [23:0] stall_pat;
      rst               = 1'b1;
      stall_i           = 1'b0;
      redirect_i        = 1'b0;
      redirect_target_i = 32'h0;

      // Boot
      drive(1, 0, 0, 0);
      drive(1, 0, 0, 0);
      check("rst_valid", {31'b0, if_valid_o}, 32'h0);
      check("rst_en", {31'b0, imem_en_o}, 32'h0);
      drive(0, 0, 0, 0);
      check("boot_en", {31'b0, imem_en_o}, 32'h0);
      drive(0, 0, 0, 0);
      check("first_en", {31'b0, imem_en_o}, 32'h1);
      check("first_addr", imem_addr_o, 32'h0);
      drive(0, 0, 0, 0);
      check("boot_pc0", if_pc_o, 32'h0);
      drive(0, 0, 0, 0);
      check("boot_pc4", if_pc_o, 32'h4);

      // Stall for three cycles on PC 0x8
      drive(0, 1, 0, 0);
      check("stall1_pc", if_pc_o, 32'h8);
      check("stall1_instr", if_instr_o, 32'h5A5A_135F);
      for (int i = 0; i < 2; i++) begin
         drive(0, 1, 0, 0);
         check("stall_pc", if_pc_o, 32'h8);
         check("stall_instr", if_instr_o, 32'h5A5A_135F);
         check("stall_en", {31'b0, imem_en_o}, 32'h0);
      end
      drive(0, 0, 0, 0);
      check("release_pc", if_pc_o, 32'h8);
      check("release_addr", imem_addr_o, 32'hC);
      drive(0, 0, 0, 0);
      check("after_release_pc", if_pc_o, 32'hC);

      // Redirect while showing 0x10
      drive(0, 0, 1, 32'h100);
      check("redir_valid", {31'b0, if_valid_o}, 32'h0);
      check("redir_addr", imem_addr_o, 32'h100);
      drive(0, 0, 0, 0);
      check("redir_pc0", if_pc_o, 32'h100);
      drive(0, 0, 0, 0);
      check("redir_pc1", if_pc_o, 32'h104);

      // Redirect during HOLD drops the buffered 0x108
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      check("hold_pc", if_pc_o, 32'h108);
      drive(0, 1, 1, 32'h200);
      check("hold_redir_valid", {31'b0, if_valid_o}, 32'h0);
      check("hold_redir_addr", imem_addr_o, 32'h200);
      drive(0, 0, 0, 0);
      check("hold_redir_pc", if_pc_o, 32'h200);
      drive(0, 0, 0, 0);
      check("hold_redir_pc1", if_pc_o, 32'h204);

      // PC wrap
      drive(0, 0, 1, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0);
      check("wrap_pc0", if_pc_o, 32'hFFFF_FFFC);
      drive(0, 0, 0, 0);
      check("wrap_pc1", if_pc_o, 32'h0);

      // Reset in the middle of a stall
      drive(0, 1, 0, 0);
      drive(0, 1, 0, 0);
      drive(1, 1, 0, 0);
      drive(0, 0, 0, 0);
      check("mid_rst_valid", {31'b0, if_valid_o}, 32'h0);
      check("mid_rst_boot_en", {31'b0, imem_en_o}, 32'h0);
      drive(0, 0, 0, 0);
      check("mid_rst_addr", imem_addr_o, 32'h0);
      drive(0, 0, 0, 0);
      check("mid_rst_pc0", if_pc_o, 32'h0);

      // Mixed stall pattern with an unaligned redirect that coincides with a stall
      stall_pat = 24'b0110_0011_1100_1101_0010_0110;
      for (int i = 0; i < 24; i++)
         drive(0, stall_pat[i], (i == 10), (i == 10) ? 32'h301 : 32'h0);
      drive(0, 0, 0, 0);
      drive(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
